// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package inst_fetch_unit_pkg;

  localparam int unsigned DEPTH_DEFAULT = 4;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned LANES         = 4;

  typedef logic [WORD_W-1:0] word_t;

  // IDLE: nothing outstanding; WAIT: request outstanding;
  // DISCARD: request outstanding whose data will be dropped.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    word_t addr;
    word_t data;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Core-side and instruction-memory-side signals of the fetch unit, bundled
// for environments that connect to the unit as a whole.
interface inst_fetch_unit_if;
  import inst_fetch_unit_pkg::*;

  word_t      inst_addr;
  logic       inst_accept;
  logic       halted;
  word_t      inst;
  logic       inst_valid;
  logic       mem_req;
  word_t      mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata [0:LANES-1];

  // Fetch unit view.
  modport master (
    input  inst_addr, inst_accept, halted, mem_ack, mem_rdata,
    output inst, inst_valid, mem_req, mem_addr
  );

  // Core / memory view.
  modport slave (
    output inst_addr, inst_accept, halted, mem_ack, mem_rdata,
    input  inst, inst_valid, mem_req, mem_addr
  );

endinterface

// File: rtl/inst_fetch_unit_fifo.sv
// Prefetch FIFO of {addr, data} entries with synchronous flush.
module fetch_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             push_entry,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  // Pointer and occupancy update; flush overrides push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents only observed when count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Sequential instruction prefetcher: one outstanding memory read at a time,
// results queued in fetch_fifo, redirect when the core's PC diverges.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] inst_addr,
  input  logic        inst_accept,
  input  logic        halted,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata [0:LANES-1]
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  fetch_state_e  state_q, state_d;
  word_t         fetch_pc_q, fetch_pc_d;
  word_t         mem_addr_q, mem_addr_d;

  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  word_t         rdata_word;
  word_t         redirect_pc;
  logic          fifo_empty, head_hit, outstanding, redirect, room;
  logic          push, pop, flush;
  logic          unused_bits;

  assign rdata_word  = {mem_rdata[3], mem_rdata[2], mem_rdata[1], mem_rdata[0]};
  assign redirect_pc = {inst_addr[31:2], 2'b00};
  assign fifo_empty  = (count == '0);
  assign head_hit    = !fifo_empty && (head.addr[31:2] == inst_addr[31:2]);
  assign outstanding = (state_q != IDLE);
  assign occupancy   = {1'b0, count} + {{CW{1'b0}}, outstanding};
  assign room        = (occupancy < DEPTH_W);
  assign pop         = head_hit && inst_accept;
  assign push_entry  = '{addr: mem_addr_q, data: rdata_word};
  assign unused_bits = ^{inst_addr[1:0], head.addr[1:0]};

  // An empty FIFO with a request in flight is not a redirect: the returning
  // entry is checked against the PC once it reaches the head.
  assign redirect = fifo_empty ? (!outstanding && (fetch_pc_q[31:2] != inst_addr[31:2]))
                               : !head_hit;

  assign inst_valid = head_hit;
  assign inst       = head_hit ? head.data : '0;
  assign mem_req    = outstanding;
  assign mem_addr   = mem_addr_q;

  // Next-state, request issue and FIFO control.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;
    flush      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
          if (!halted) begin
            state_d    = WAIT;
            mem_addr_d = redirect_pc;
          end
        end else if (!halted && room) begin
          state_d    = WAIT;
          mem_addr_d = fetch_pc_q;
        end
      end
      WAIT: begin
        if (redirect) begin
          flush = 1'b1;
          if (mem_ack) begin
            fetch_pc_d = redirect_pc;
            state_d    = IDLE;
          end else begin
            state_d = DISCARD;
          end
        end else if (mem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          // Occupancy still counts the completing request, so a reissue
          // here can never find the FIFO full when its ack returns.
          if (!halted && room) mem_addr_d = fetch_pc_q + 32'd4;
          else                 state_d    = IDLE;
        end
      end
      DISCARD: begin
        if (mem_ack) begin
          fetch_pc_d = redirect_pc;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, fetch PC and request address registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_b      (rst_b),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_entry (push_entry),
    .head       (head),
    .count      (count)
  );

endmodule
